serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 95 +++++++++
 tb/tb_serial_subtractor.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell and one borrow flop, LSB first.
// Optional signed-overflow output guarded by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bo
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             diff_bit;
    logic             br_next;
    logic             last;
    logic             accept;

    assign diff_bit = a_reg[0] ^ b_reg[0] ^ br;
    assign br_next  = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & br);
    assign last     = (cnt == CW'(WIDTH - 1));
    assign accept   = start && (state != RUN);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Difference bits enter a_reg from the top as minuend bits leave the bottom,
    // so after WIDTH cycles a_reg holds the full result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            D     <= '0;
            Bo    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            a_reg <= A;
            b_reg <= B;
            br    <= Bin;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_reg <= {diff_bit, a_reg[WIDTH-1:1]};
            b_reg <= b_reg >> 1;
            br    <= br_next;
            cnt   <= cnt + 1'b1;
            if (last) begin
                D  <= {diff_bit, a_reg[WIDTH-1:1]};
                Bo <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                ovf <= br ^ br_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4); checks ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bo;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .Bin   (Bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bo    (Bo)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t e;
        int   sr;
        e.d   = W'(int'(a) - int'(b) - int'(bin));
        e.bo  = (int'(a) < int'(b) + int'(bin));
        sr    = int'($signed(a)) - int'($signed(b)) - int'(bin);
        e.ovf = (sr < -8) || (sr > 7);
        return e;
    endfunction

    // Call at a falling edge; start is captured at the following rising edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input exp_t e);
        A = a; B = b; Bin = bin; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("busy_done_excl", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("D", {28'd0, D}, {28'd0, e.d});
                chk("Bo", {31'd0, Bo}, {31'd0, e.bo});
`ifdef SERIAL_SUB_OVF_EN
                chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        exp_t         e;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat;
        vecs[0] = '{a: 4'h9, b: 4'h4, bin: 1'b0, e: '{d: 4'h5, bo: 1'b0, ovf: 1'b1}};
        vecs[1] = '{a: 4'h3, b: 4'h5, bin: 1'b0, e: '{d: 4'hE, bo: 1'b1, ovf: 1'b0}};
        vecs[2] = '{a: 4'h0, b: 4'h0, bin: 1'b1, e: '{d: 4'hF, bo: 1'b1, ovf: 1'b0}};
        vecs[3] = '{a: 4'h8, b: 4'h1, bin: 1'b0, e: '{d: 4'h7, bo: 1'b0, ovf: 1'b1}};
        vecs[4] = '{a: 4'h6, b: 4'h2, bin: 1'b0, e: '{d: 4'h4, bo: 1'b0, ovf: 1'b0}};

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_D", {28'd0, D}, 32'd0);
        chk("rst_Bo", {31'd0, Bo}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // First op from IDLE: latency, busy and output hold during RUN
        issue(vecs[0].a, vecs[0].b, vecs[0].bin, vecs[0].e);
        chk("busy_run", {31'd0, busy}, 32'd1);
        chk("D_hold_run", {28'd0, D}, 32'd0);
        wait_done(lat);
        chk("latency", lat, W);

        // Remaining directed vectors back-to-back from the DONE cycle
        for (int i = 1; i < 5; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].e);
            wait_done(lat);
            chk("latency_b2b", lat, W);
        end

        // start held high with inputs changing during RUN; restart on DONE cycle
        A = 4'h2; B = 4'h1; Bin = 1'b0; start = 1'b1;
        sb.push_back('{d: 4'h1, bo: 1'b0, ovf: 1'b0});
        @(negedge clk); A = 4'hF; B = 4'h3; Bin = 1'b1;
        @(negedge clk); A = 4'h5; B = 4'h9; Bin = 1'b0;
        @(negedge clk); A = 4'hC; B = 4'h4; Bin = 1'b1;
        @(negedge clk); A = 4'h6; B = 4'h2; Bin = 1'b0;
        @(negedge clk);
        chk("held_done", {31'd0, done}, 32'd1);
        sb.push_back('{d: 4'h4, bo: 1'b0, ovf: 1'b0});
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("held_next_latency", lat, W);

        // Reset in RUN cycle 2 aborts with no done pulse
        @(negedge clk);
        issue(4'h8, 4'h1, 1'b0, '{d: 4'h7, bo: 1'b0, ovf: 1'b1});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_D", {28'd0, D}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        issue(4'h7, 4'h7, 1'b0, '{d: 4'h0, bo: 1'b0, ovf: 1'b0});
        wait_done(lat);
        chk("post_reset_latency", lat, W);

        // Full sweep against the arithmetic model, back-to-back
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    issue(W'(a), W'(b), c[0], ref_model(W'(a), W'(b), c[0]));
                    wait_done(lat);
                    if (lat != W) chk("sweep_latency", lat, W);
                end
            end
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
